// File: rtl/writeback_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : writeback_arbiter (with package writeback_pkg)               |
// | Description : Writeback stage in front of the register file. Buffers ALU   |
// |               and LSU results in small per-source FIFOs. Arbitrates them   |
// |               round-robin into one registered write per cycle. Publishes a |
// |               pending-write mask for issue-stage hazard detection.         |
// | Options     : define WB_PERF_EN to add the oConflictCnt / oDropCnt         |
// |               performance counters.                                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

package writeback_pkg;
   localparam int RegWidth     = 32;
   localparam int RegAddrWidth = 5;

   // Register-file write transport: {addr, value}.
   typedef struct packed {
      logic [RegAddrWidth-1:0] addr;
      logic [RegWidth-1:0]     value;
   } reg_transport_t;
endpackage

module writeback_arbiter
   import writeback_pkg::*;
#(
   parameter int N_REGS     = 32,
   parameter int REG_WIDTH  = RegWidth,
   parameter int ADDR_WIDTH = RegAddrWidth,
   parameter int DEPTH      = 2
) (
   input  logic                iClk,
   input  logic                nRst,
   input  logic                iAluValid,
   output logic                oAluReady,
   input  reg_transport_t      iAluRd,
   input  logic                iLsuValid,
   output logic                oLsuReady,
   input  reg_transport_t      iLsuRd,
   output logic                oWriteEn,
   output reg_transport_t      oRd,
   output logic [N_REGS-1:0]   oPendingMask
`ifdef WB_PERF_EN
   ,
   output logic [31:0]         oConflictCnt,
   output logic [31:0]         oDropCnt
`endif
);

   // Entry layout matches reg_transport_t: address in the upper bits.
   localparam int   c_ENTRY_W = ADDR_WIDTH + REG_WIDTH;
   localparam int   c_IDX_W   = $clog2(DEPTH);
   localparam int   c_PTR_W   = c_IDX_W + 1;
   localparam logic c_ALU     = 1'b0;
   localparam logic c_LSU     = 1'b1;

   // Source 0 is the ALU, source 1 is the LSU.
   logic [1:0]                w_in_valid;
   logic [1:0][c_ENTRY_W-1:0] w_in_data;
   logic [1:0]                w_full;
   logic [1:0]                w_empty;
   logic [1:0]                w_push;
   logic [1:0]                w_pop;
   logic [1:0][c_ENTRY_W-1:0] w_head;
   logic [1:0][N_REGS-1:0]    w_fifo_mask;
`ifdef WB_PERF_EN
   logic [1:0]                w_drop;
`endif

   logic                      w_both;
   logic                      w_grant_valid;
   logic                      w_grant_src;
   logic [N_REGS-1:0]         w_out_mask;

   logic                      r_write_en;
   logic [c_ENTRY_W-1:0]      r_rd;
   logic                      r_last_grant;

   assign w_in_valid   = {iLsuValid, iAluValid};
   assign w_in_data[0] = iAluRd;
   assign w_in_data[1] = iLsuRd;

   // Ready comes only from stored occupancy, so a full FIFO stays
   // not-ready for the whole cycle even if its head is being drained.
   assign oAluReady = ~w_full[0];
   assign oLsuReady = ~w_full[1];

   generate
      for (genvar s = 0; s < 2; s++) begin : g_fifo
         logic [c_ENTRY_W-1:0] r_mem [DEPTH];
         logic [c_PTR_W-1:0]   r_wptr;
         logic [c_PTR_W-1:0]   r_rptr;
         logic [c_PTR_W-1:0]   w_count;
         logic [c_IDX_W-1:0]   w_idx;
         logic [N_REGS-1:0]    w_mask;
         logic                 w_accept;
         logic                 w_is_x0;

         assign w_full[s]  = (r_wptr[c_PTR_W-1] != r_rptr[c_PTR_W-1]) &&
                             (r_wptr[c_IDX_W-1:0] == r_rptr[c_IDX_W-1:0]);
         assign w_empty[s] = (r_wptr == r_rptr);
         assign w_count    = r_wptr - r_rptr;

         // Writes to x0 are handshaken but never buffered.
         assign w_accept   = w_in_valid[s] & ~w_full[s];
         assign w_is_x0    = (w_in_data[s][c_ENTRY_W-1 -: ADDR_WIDTH] == '0);
         assign w_push[s]  = w_accept & ~w_is_x0;
`ifdef WB_PERF_EN
         assign w_drop[s]  = w_accept & w_is_x0;
`endif

         assign w_head[s]  = r_mem[r_rptr[c_IDX_W-1:0]];

         // Pointer update; the pointer MSB distinguishes full from empty.
         always_ff @(posedge iClk or negedge nRst) begin
            if (!nRst) begin
               r_wptr <= '0;
               r_rptr <= '0;
            end else begin
               if (w_push[s]) begin
                  r_wptr <= r_wptr + c_PTR_W'(1);
               end
               if (w_pop[s]) begin
                  r_rptr <= r_rptr + c_PTR_W'(1);
               end
            end
         end

         // Payload storage; contents are meaningless outside the valid window.
         always_ff @(posedge iClk) begin
            if (w_push[s]) begin
               r_mem[r_wptr[c_IDX_W-1:0]] <= w_in_data[s];
            end
         end

         // One-hot OR of the destination of every occupied slot.
         always_comb begin
            w_mask = '0;
            w_idx  = '0;
            for (int i = 0; i < DEPTH; i++) begin
               w_idx = r_rptr[c_IDX_W-1:0] + c_IDX_W'(i);
               if (c_PTR_W'(i) < w_count) begin
                  w_mask = w_mask | (N_REGS'(1) << r_mem[w_idx][c_ENTRY_W-1 -: ADDR_WIDTH]);
               end
            end
         end

         assign w_fifo_mask[s] = w_mask;
      end
   endgenerate

   // Round-robin between the two heads; a lone head is granted outright.
   assign w_both        = ~w_empty[0] & ~w_empty[1];
   assign w_grant_valid = ~w_empty[0] | ~w_empty[1];
   assign w_grant_src   = w_both ? ~r_last_grant : w_empty[0];
   assign w_pop[0]      = w_grant_valid & (w_grant_src == c_ALU);
   assign w_pop[1]      = w_grant_valid & (w_grant_src == c_LSU);

   // Output register; oRd keeps its last value when nothing is granted.
   always_ff @(posedge iClk or negedge nRst) begin
      if (!nRst) begin
         r_write_en   <= 1'b0;
         r_rd         <= '0;
         r_last_grant <= c_LSU;
      end else begin
         r_write_en <= w_grant_valid;
         if (w_grant_valid) begin
            r_rd <= w_grant_src ? w_head[1] : w_head[0];
         end
         if (w_both) begin
            r_last_grant <= w_grant_src;
         end
      end
   end

   assign oWriteEn = r_write_en;
   assign oRd      = r_rd;

   assign w_out_mask   = r_write_en ? (N_REGS'(1) << r_rd[c_ENTRY_W-1 -: ADDR_WIDTH])
                                    : '0;
   assign oPendingMask = (w_fifo_mask[0] | w_fifo_mask[1] | w_out_mask) &
                         ~N_REGS'(1);

`ifdef WB_PERF_EN
   logic [31:0] r_conflict_cnt;
   logic [31:0] r_drop_cnt;

   // Contested cycles and discarded x0 writes; both wrap naturally.
   always_ff @(posedge iClk or negedge nRst) begin
      if (!nRst) begin
         r_conflict_cnt <= '0;
         r_drop_cnt     <= '0;
      end else begin
         if (w_both) begin
            r_conflict_cnt <= r_conflict_cnt + 32'd1;
         end
         r_drop_cnt <= r_drop_cnt + 32'(w_drop[0]) + 32'(w_drop[1]);
      end
   end

   assign oConflictCnt = r_conflict_cnt;
   assign oDropCnt     = r_drop_cnt;
`endif

endmodule
`default_nettype wire
